// File: rtl/m_ser_pkg.sv
// m_ser_pkg: definitions shared by the m_ser link receiver and transmitter.
// The frame length depends on whether M_SER_RX_PARITY_EN is compiled in.
package m_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } ser_state_e;

    localparam int unsigned W_DEFAULT = 8;

    // Start bit, W data bits, and an optional trailing parity bit.
    function automatic int unsigned frame_len(int unsigned w, bit parity);
        return 32'd1 + w + (parity ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/m_ser_rx_fifo2.sv
// m_ser_rx_fifo2: 2-entry FIFO buffer for received words.
// A push into a full buffer succeeds only when a pop happens on the same edge.
module m_ser_rx_fifo2
    import m_ser_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         CK,
    input  logic         R,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;
    logic         do_push;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : slot0_q;

    // Pop first, then place the push behind whatever remains.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        if (do_pop) begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
        end
        if (do_push) begin
            if (cnt_d == 2'd0) begin
                slot0_d = din_i;
            end else begin
                slot1_d = din_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge CK) begin
        if (R) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/m_ser_rx.sv
// m_ser_rx: serial-link receiver, start bit then W data bits LSB-first.
// Define M_SER_RX_PARITY_EN to add a trailing even-parity bit per frame.
module m_ser_rx
    import m_ser_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         CK,
    input  logic         R,
    input  logic         SDI,
    output logic [W-1:0] DOUT,
    output logic         DVALID,
    input  logic         DREADY,
    output logic         ERR_OVF,
    output logic         ERR_PAR
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    ser_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0] shift_q;
    logic [W-1:0] word_d;
    logic [W-1:0] push_word;
    logic         push_req;
    logic         pop;
    logic         full;
    logic         empty;
    logic         err_ovf_q;

    // Word as it stands once the bit on SDI is merged in.
    always_comb begin
        word_d        = shift_q;
        word_d[cnt_q] = SDI;
    end

`ifdef M_SER_RX_PARITY_EN
    logic par_bad;
    logic err_par_q;

    assign push_req  = (state_q == PAR) && (SDI == ^shift_q);
    assign par_bad   = (state_q == PAR) && (SDI != ^shift_q);
    assign push_word = shift_q;
    assign ERR_PAR   = err_par_q;
`else
    assign push_req  = (state_q == DATA) && (cnt_q == LAST);
    assign push_word = word_d;
    assign ERR_PAR   = 1'b0;
`endif

    assign pop     = DVALID && DREADY;
    assign DVALID  = !empty;
    assign ERR_OVF = err_ovf_q;

    always_ff @(posedge CK) begin
        if (R) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            err_ovf_q <= 1'b0;
`ifdef M_SER_RX_PARITY_EN
            err_par_q <= 1'b0;
`endif
        end else begin
            err_ovf_q <= push_req && full && !pop;
`ifdef M_SER_RX_PARITY_EN
            err_par_q <= par_bad;
`endif
            case (state_q)
                IDLE: begin
                    if (SDI) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end
                DATA: begin
                    shift_q <= word_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
`ifdef M_SER_RX_PARITY_EN
                        state_q <= PAR;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef M_SER_RX_PARITY_EN
                PAR: begin
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    m_ser_rx_fifo2 #(
        .W(W)
    ) u_fifo (
        .CK     (CK),
        .R      (R),
        .push_i (push_req),
        .pop_i  (pop),
        .din_i  (push_word),
        .dout_o (DOUT),
        .full_o (full),
        .empty_o(empty)
    );

endmodule
